// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: ALU and load unit share one register-file write port.
// Each write holds data one cycle (SETUP), strobes until acknowledged or timed out, then grants.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and latches the winner's data
// SETUP   | destReg/destVal stable, strobe still low
// STROBE  | storeNow high, waiting on storeDone or timeout
// RELEASE | strobe low, one-cycle grant pulse to the winner
module wb_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic [3:0]  alu_reg,
  input  logic [15:0] alu_val,
  output logic        alu_grant,
  input  logic        mem_req,
  input  logic [3:0]  mem_reg,
  input  logic [15:0] mem_val,
  output logic        mem_grant,
  output logic [3:0]  destReg,
  output logic [15:0] destVal,
  output logic        storeNow,
  input  logic        storeDone,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state, stateNext;
  logic        ptrMem, ptrMemNext;
  logic        winMem, winMemNext;
  logic        pickMem;
  logic [3:0]  cnt, cntNext;
  logic        errNext;
  logic [3:0]  destRegNext;
  logic [15:0] destValNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptrMem    <= 1'b0;
      winMem    <= 1'b0;
      cnt       <= 4'd0;
      err       <= 1'b0;
      destReg   <= 4'd0;
      destVal   <= 16'd0;
      storeNow  <= 1'b0;
      busy      <= 1'b0;
      alu_grant <= 1'b0;
      mem_grant <= 1'b0;
    end else begin
      state     <= stateNext;
      ptrMem    <= ptrMemNext;
      winMem    <= winMemNext;
      cnt       <= cntNext;
      err       <= errNext;
      destReg   <= destRegNext;
      destVal   <= destValNext;
      // Outputs are registered copies of what the next state implies.
      storeNow  <= (stateNext == STROBE);
      busy      <= (stateNext != IDLE);
      alu_grant <= (stateNext == RELEASE) && !winMemNext;
      mem_grant <= (stateNext == RELEASE) && winMemNext;
    end
  end

  always_comb begin
    stateNext   = state;
    ptrMemNext  = ptrMem;
    winMemNext  = winMem;
    cntNext     = cnt;
    errNext     = err;
    destRegNext = destReg;
    destValNext = destVal;
    pickMem     = 1'b0;
    case (state)
      IDLE: begin
        if (alu_req || mem_req) begin
          // Contention goes to the pointer side; the loser gets the pointer.
          pickMem     = mem_req && (!alu_req || ptrMem);
          winMemNext  = pickMem;
          ptrMemNext  = !pickMem;
          destRegNext = pickMem ? mem_reg : alu_reg;
          destValNext = pickMem ? mem_val : alu_val;
          stateNext   = SETUP;
        end
      end
      SETUP: begin
        cntNext   = 4'd1;
        stateNext = STROBE;
      end
      STROBE: begin
        if (storeDone) begin
          stateNext = RELEASE;
        end else if (cnt == TimeoutCnt) begin
          errNext   = 1'b1;
          stateNext = RELEASE;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      RELEASE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle transaction model check plus directed literal scenarios.
module tb_wb_arbiter;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_req = 1'b0, mem_req = 1'b0;
  logic [3:0]  alu_reg = '0, mem_reg = '0;
  logic [15:0] alu_val = '0, mem_val = '0;
  logic        alu_grant, mem_grant, storeNow, busy, err;
  logic        storeDone = 1'b0;
  logic [3:0]  destReg;
  logic [15:0] destVal;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_val(alu_val), .alu_grant(alu_grant),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_val(mem_val), .mem_grant(mem_grant),
    .destReg(destReg), .destVal(destVal), .storeNow(storeNow), .storeDone(storeDone),
    .busy(busy), .err(err)
  );

  typedef struct {logic [3:0] rg; logic [15:0] vl;} wr_t;
  wr_t aluQ[$];
  wr_t memQ[$];
  int  grantMem[$];
  int  grantTick[$];
  int  total = 0, bad = 0;
  int  tickN = 0, grantCount = 0;
  int  curRun = 0, lastRun = 0, strobeSeen = 0, doneDelay = 0;
  bit  prevSN = 1'b0;
  logic [15:0] rf [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a write is a timeline measured in cycles since the arbitration edge.
  bit          mActive = 0, mWinMem = 0, mMemTurn = 0, mErr = 0;
  int          mAge = 0, mRelAge = 0;
  logic [3:0]  mReg = '0;
  logic [15:0] mVal = '0;

  always @(posedge clk) begin
    if (!rst) begin
      mActive = 0; mWinMem = 0; mMemTurn = 0; mErr = 0;
      mAge = 0; mRelAge = 0; mReg = '0; mVal = '0;
    end else if (mActive) begin
      if (mRelAge != 0 && mAge == mRelAge) begin
        mActive = 0;
      end else begin
        if (mAge >= 2 && mRelAge == 0 && (storeDone || (mAge - 1) == TIMEOUT)) begin
          mRelAge = mAge + 1;
          if (!storeDone) mErr = 1;
        end
        mAge++;
      end
    end else if (alu_req || mem_req) begin
      mWinMem  = mem_req && (!alu_req || mMemTurn);
      mMemTurn = !mWinMem;
      mReg     = mWinMem ? mem_reg : alu_reg;
      mVal     = mWinMem ? mem_val : alu_val;
      mActive  = 1; mAge = 1; mRelAge = 0;
    end
    #1;
    check("m_busy",     32'(busy),      32'(mActive));
    check("m_storeNow", 32'(storeNow),  32'(mActive && mAge >= 2 && mRelAge == 0));
    check("m_aluGrant", 32'(alu_grant), 32'(mActive && mAge == mRelAge && !mWinMem));
    check("m_memGrant", 32'(mem_grant), 32'(mActive && mAge == mRelAge && mWinMem));
    check("m_err",      32'(err),       32'(mErr));
    check("m_destReg",  32'(destReg),   32'(mReg));
    check("m_destVal",  32'(destVal),   32'(mVal));
  end

  task automatic refreshReqs();
    alu_req = (aluQ.size() > 0);
    mem_req = (memQ.size() > 0);
    alu_reg = alu_req ? aluQ[0].rg : 4'd0;
    alu_val = alu_req ? aluQ[0].vl : 16'd0;
    mem_reg = mem_req ? memQ[0].rg : 4'd0;
    mem_val = mem_req ? memQ[0].vl : 16'd0;
  endtask

  task automatic pushAlu(input logic [3:0] r, input logic [15:0] v);
    wr_t w;
    w.rg = r; w.vl = v;
    aluQ.push_back(w);
    refreshReqs();
  endtask

  task automatic pushMem(input logic [3:0] r, input logic [15:0] v);
    wr_t w;
    w.rg = r; w.vl = v;
    memQ.push_back(w);
    refreshReqs();
  endtask

  task automatic tick();
    @(negedge clk);
    tickN++;
    if (storeNow) begin
      if (!prevSN) rf[destReg] = destVal;
      curRun++;
    end else if (prevSN) begin
      lastRun = curRun;
      curRun = 0;
    end
    prevSN = storeNow;
    if (alu_grant) begin
      grantCount++; grantMem.push_back(0); grantTick.push_back(tickN);
      if (aluQ.size() > 0) aluQ.delete(0);
    end
    if (mem_grant) begin
      grantCount++; grantMem.push_back(1); grantTick.push_back(tickN);
      if (memQ.size() > 0) memQ.delete(0);
    end
    if (doneDelay == 0) storeDone = 1'b1;
    else if (storeNow) begin
      strobeSeen++;
      storeDone = (strobeSeen >= doneDelay);
    end else begin
      strobeSeen = 0;
      storeDone = 1'b0;
    end
    refreshReqs();
  endtask

  task automatic waitGrants(input int n, input int bound, output int cycles);
    int start;
    start = tickN;
    while (grantCount < n && tickN - start < bound) tick();
    cycles = tickN - start;
    check("grants_within_bound", 32'(grantCount >= n), 32'd1);
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    grantMem.delete(); grantTick.delete(); grantCount = 0;
  endtask

  initial begin
    int cyc, gc;
    for (int i = 0; i < 16; i++) rf[i] = 16'd0;
    doneDelay = 0;
    storeDone = 1'b1;
    tick();
    tick();
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_storeNow", 32'(storeNow), 32'd0);
    check("rst_destReg",  32'(destReg),  32'd0);
    check("rst_destVal",  32'(destVal),  32'd0);
    check("rst_err",      32'(err),      32'd0);
    rst = 1'b1;

    // Single ALU write with acknowledge tied high.
    pushAlu(4'd3, 16'h1234);
    waitGrants(grantCount + 1, 20, cyc);
    check("t1_latency",   32'(cyc),      32'd3);
    check("t1_destReg",   32'(destReg),  32'd3);
    check("t1_destVal",   32'(destVal),  32'h1234);
    check("t1_strobeLen", 32'(lastRun),  32'd1);
    check("t1_winnerAlu", 32'(grantMem[grantMem.size()-1]), 32'd0);
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // Four back-to-back contended pairs alternate starting with ALU.
    doReset();
    for (int i = 0; i < 4; i++) begin
      pushAlu(4'd5, 16'hAAAA);
      pushMem(4'd6, 16'h5555);
    end
    waitGrants(8, 100, cyc);
    for (int i = 0; i < 8 && i < grantMem.size(); i++)
      check("t2_order", 32'(grantMem[i]), 32'(i % 2));
    for (int i = 1; i < 8 && i < grantTick.size(); i++)
      check("t2_spacing", 32'(grantTick[i] - grantTick[i-1]), 32'd4);
    tick();

    // Same destination from both: ALU first, load data is final.
    doReset();
    rf[7] = 16'd0;
    pushAlu(4'd7, 16'h0001);
    pushMem(4'd7, 16'h0002);
    waitGrants(2, 30, cyc);
    check("t3_r7", 32'(rf[7]), 32'h0002);
    if (grantMem.size() >= 2) begin
      check("t3_first",  32'(grantMem[0]), 32'd0);
      check("t3_second", 32'(grantMem[1]), 32'd1);
    end
    tick();

    // Timeout: no acknowledge, strobe limited to TIMEOUT cycles, err sticky.
    doneDelay = 1000; storeDone = 1'b0; strobeSeen = 0;
    pushAlu(4'd1, 16'h0BAD);
    waitGrants(grantCount + 1, 40, cyc);
    check("t4_latency",   32'(cyc),     32'd17);
    check("t4_strobeLen", 32'(lastRun), 32'd15);
    check("t4_err",       32'(err),     32'd1);
    tick();
    doneDelay = 0; storeDone = 1'b1;
    pushMem(4'd2, 16'h2222);
    waitGrants(grantCount + 1, 20, cyc);
    check("t4_errSticky", 32'(err),     32'd1);
    check("t4_nextLen",   32'(lastRun), 32'd1);
    check("t4_nextVal",   32'(destVal), 32'h2222);
    tick();

    // Reset during STROBE aborts the write; held request is served afterwards.
    doneDelay = 1000; storeDone = 1'b0; strobeSeen = 0;
    pushAlu(4'd4, 16'h4444);
    for (int k = 0; k < 10 && !storeNow; k++) tick();
    check("t5_inStrobe", 32'(storeNow), 32'd1);
    tick();
    tick();
    gc = grantCount;
    rst = 1'b0;
    tick();
    check("t5_storeNow", 32'(storeNow), 32'd0);
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_err",      32'(err),      32'd0);
    check("t5_noGrant",  32'(grantCount), 32'(gc));
    rst = 1'b1;
    doneDelay = 0; storeDone = 1'b1;
    waitGrants(gc + 1, 20, cyc);
    check("t5_latency", 32'(cyc),     32'd3);
    check("t5_destReg", 32'(destReg), 32'd4);
    check("t5_destVal", 32'(destVal), 32'h4444);
    tick();

    // Acknowledge arrives on the third strobe cycle.
    doneDelay = 3; storeDone = 1'b0; strobeSeen = 0;
    pushMem(4'd9, 16'h9999);
    waitGrants(grantCount + 1, 20, cyc);
    check("t6_latency",   32'(cyc),     32'd5);
    check("t6_strobeLen", 32'(lastRun), 32'd3);
    check("t6_err",       32'(err),     32'd0);
    check("t6_destReg",   32'(destReg), 32'd9);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
